// File: rtl/posit_pkg.sv
// posit_pkg: width helpers and the decoded regime bundle
// shared by the posit regime decoder and its consumers.
package posit_pkg;

    localparam int MAX_N = 64;

    function automatic int run_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int k_w(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int MAX_CW = run_w(MAX_N);
    localparam int MAX_KW = k_w(MAX_N);

    // Sized for the widest legal posit; narrower posits
    // use the low bits of run/k and the high bits of rem.
    typedef struct packed {
        logic              sign;
        logic [MAX_CW-1:0] run;
        logic [MAX_KW-1:0] k;
        logic [MAX_N-2:0]  rem;
        logic              zero;
        logic              nar;
    } posit_regime_t;

endpackage

// File: rtl/posit_run_count.sv
// posit_run_count: leading-run counter, split into a 2-bit
// pair encoder and a log2 reduction tree over the pair codes.
module posit_run_count #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic [N-2:0]  bits,
    input  logic          lead,
    output logic [N-1:0]  pairs,
    input  logic [N-1:0]  pairs_q,
    output logic [CW-1:0] run
);

    localparam int P  = N / 2;
    localparam int LV = $clog2(P);

    logic [N-1:0] match;

    // A trailing 0 terminates every run, so the count saturates at N-1.
    assign match = {~(bits ^ {(N-1){lead}}), 1'b0};

    // Pair code: 2'b10 = both bits match, 2'b01 = only the upper one.
    always_comb begin
        pairs = '0;
        for (int j = 0; j < P; j++) begin
            pairs[2*j+1] = match[2*j+1] & match[2*j];
            pairs[2*j]   = match[2*j+1] & ~match[2*j];
        end
    end

    // Halve the node list each level; a full left node adds its right sibling.
    always_comb begin
        logic [CW-1:0] cnt [P];
        logic [P-1:0]  full;
        full = '0;
        for (int a = 0; a < P; a++) begin
            cnt[a]  = {{(CW-2){1'b0}}, pairs_q[2*(P-1-a)+1 -: 2]};
            full[a] = pairs_q[2*(P-1-a)+1];
        end
        for (int l = 0; l < LV; l++) begin
            for (int a = 0; a < P / 2; a++) begin
                if (a < (P >> (l + 1))) begin
                    cnt[a]  = cnt[2*a] + (full[2*a] ? cnt[2*a+1] : '0);
                    full[a] = full[2*a] & full[2*a+1];
                end
            end
        end
        run = cnt[0];
    end

endmodule

// File: rtl/posit_regime_decode_pipe.sv
// posit_regime_decode_pipe: two-stage posit regime decoder with
// valid/ready handshake and a single global stall.
module posit_regime_decode_pipe
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = run_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_posit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [CW-1:0]        out_run,
    output logic signed [CW:0]   out_k,
    output logic [N-2:0]         out_rem,
    output logic                 out_zero,
    output logic                 out_nar
);

    localparam int KW = CW + 1;
    localparam logic [N-2:0]  BODY_ONE = {{(N-2){1'b0}}, 1'b1};
    localparam logic [CW-1:0] RUN_LIM  = CW'(N - 2);

    logic          advance;
    logic          sign_in;
    logic [N-2:0]  body_in;
    logic [N-2:0]  neg_in;
    logic          body_zero;
    logic [N-1:0]  pairs_in;

    logic          s1_valid;
    logic          s1_sign;
    logic          s1_zero;
    logic          s1_nar;
    logic [N-2:0]  s1_body;
    logic [N-1:0]  s1_pairs;

    logic [CW-1:0] run_raw;
    logic          special;
    logic [CW:0]   run_x;
    logic [CW:0]   shamt;
    logic [CW-1:0] run_c;
    logic [CW:0]   k_c;
    logic [N-2:0]  rem_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign sign_in   = in_posit[N-1];
    assign body_in   = in_posit[N-2:0];
    assign neg_in    = sign_in ? (~body_in + BODY_ONE) : body_in;
    assign body_zero = (body_in == '0);

    posit_run_count #(
        .N  (N),
        .CW (CW)
    ) u_run (
        .bits    (neg_in),
        .lead    (neg_in[N-2]),
        .pairs   (pairs_in),
        .pairs_q (s1_pairs),
        .run     (run_raw)
    );

    // Stage 1: capture sign, negated body, specials and pair codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_body  <= '0;
            s1_pairs <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign  <= sign_in;
                s1_zero  <= body_zero & ~sign_in;
                s1_nar   <= body_zero & sign_in;
                s1_body  <= neg_in;
                s1_pairs <= pairs_in;
            end
        end
    end

    // Stage 2 datapath: zero and NaR force run, k and rem to 0.
    always_comb begin
        special = s1_zero | s1_nar;
        run_x   = {1'b0, run_raw};
        shamt   = run_x + KW'(1);
        run_c   = special ? '0 : run_raw;
        k_c     = '0;
        rem_c   = '0;
        if (!special) begin
            k_c = s1_body[N-2] ? (run_x - KW'(1)) : (KW'(0) - run_x);
            if (run_raw < RUN_LIM) begin
                rem_c = s1_body << shamt;
            end
        end
    end

    // Stage 2 registers drive the outputs and hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_run   <= '0;
            out_k     <= '0;
            out_rem   <= '0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                out_run  <= run_c;
                out_k    <= k_c;
                out_rem  <= rem_c;
                out_zero <= s1_zero;
                out_nar  <= s1_nar;
            end
        end
    end

endmodule
